// File: rtl/twos_decoder_pkg.sv
// Shared definitions for the two's-complement to sign-magnitude decoder.
// The default width is shared with the negation and adder blocks of the datapath.
package twos_decoder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/twos_serial_cell.sv
// One bit of the copy-until-first-one-then-invert conversion, LSB first.
// Bits of a positive operand pass straight through.
module twos_serial_cell (
    input  logic b,
    input  logic sign,
    input  logic seen_one,
    output logic out_bit,
    output logic seen_one_next
);

    // A negative operand copies bits up to and including the first one, then inverts the rest.
    assign out_bit       = sign ? (seen_one ? ~b : b) : b;
    assign seen_one_next = seen_one | b;

endmodule

// File: rtl/twos_decoder.sv
// Bit-serial two's-complement to sign-magnitude decoder with an en/ready handshake.
// A conversion takes WIDTH shift cycles followed by a single-cycle ready pulse.
module twos_decoder
    import twos_decoder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] Output,
    output logic             sign,
    output logic             is_min,
    output logic             busy,
    output logic             ready
);

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_out;
    logic             r_sign;
    logic             r_isMin;
    logic             r_seenOne;
    logic [CNT_W-1:0] r_cnt;

    logic             w_capture;
    logic             w_lastBit;
    logic             w_outBit;
    logic             w_seenOneNext;

    twos_serial_cell u_cell (
        .b             (r_shreg[0]),
        .sign          (r_sign),
        .seen_one      (r_seenOne),
        .out_bit       (w_outBit),
        .seen_one_next (w_seenOneNext)
    );

    assign w_lastBit = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // DONE accepts a new request directly so conversions can run back to back.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    w_nextState = en ? SHIFT : IDLE;
            SHIFT:   w_nextState = w_lastBit ? DONE : SHIFT;
            DONE:    w_nextState = en ? SHIFT : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == SHIFT);
        ready     = (r_state == DONE);
        w_capture = en && ((r_state == IDLE) || (r_state == DONE));
    end

    // Result bits enter from the MSB side, so after WIDTH shifts the first bit sits at bit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg   <= '0;
            r_out     <= '0;
            r_sign    <= 1'b0;
            r_isMin   <= 1'b0;
            r_seenOne <= 1'b0;
            r_cnt     <= '0;
        end else if (w_capture) begin
            r_shreg   <= A;
            r_sign    <= A[WIDTH-1];
            r_isMin   <= A[WIDTH-1] & ~(|A[WIDTH-2:0]);
            r_seenOne <= 1'b0;
            r_cnt     <= '0;
        end else if (r_state == SHIFT) begin
            r_out     <= {w_outBit, r_out[WIDTH-1:1]};
            r_shreg   <= {1'b0, r_shreg[WIDTH-1:1]};
            r_seenOne <= w_seenOneNext;
            r_cnt     <= r_cnt + 1'b1;
        end
    end

    assign Output = r_out;
    assign sign   = r_sign;
    assign is_min = r_isMin;

endmodule

// File: tb/tb_twos_decoder.sv
// Directed scoreboard bench for twos_decoder: expected results are queued at capture
// and compared when ready pulses.
module tb_twos_decoder;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] mag;
        logic         sgn;
        logic         isMin;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [W-1:0] A;
    logic [W-1:0] Output;
    logic         sign;
    logic         is_min;
    logic         busy;
    logic         ready;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    twos_decoder #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .A      (A),
        .Output (Output),
        .sign   (sign),
        .is_min (is_min),
        .busy   (busy),
        .ready  (ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives en for one cycle starting at the current negedge and queues the expected result.
    task automatic applyStimulus(input logic [W-1:0] a);
        exp_t e;
        en      = 1'b1;
        A       = a;
        e.mag   = a[W-1] ? (~a + 1'b1) : a;
        e.sgn   = a[W-1];
        e.isMin = (a == 8'h80);
        expQ.push_back(e);
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        check({tag, ".queued"}, (expQ.size() != 0), 1);
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            check({tag, ".Output"}, Output, e.mag);
            check({tag, ".sign"}, sign, e.sgn);
            check({tag, ".is_min"}, is_min, e.isMin);
        end
    endtask

    // Called one negedge after the capture edge; ready must appear W negedges later.
    task automatic waitAndCheck(input string tag, input logic spam, input logic [W-1:0] spamA);
        int k = 0;
        int busyCnt = 0;
        while (!ready && k < 40) begin
            if (busy) busyCnt++;
            if (spam) begin
                en = 1'b1;
                A  = spamA;
            end
            @(negedge clk);
            k++;
        end
        en = 1'b0;
        check({tag, ".latency"}, k, W);
        check({tag, ".busyCycles"}, busyCnt, W);
        check({tag, ".ready"}, ready, 1);
        checkOutput(tag);
    endtask

    task automatic expectNoReady(input string tag, input int n);
        int seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (ready) seen++;
        end
        check(tag, seen, 0);
    endtask

    task automatic checkPulseEnd(input string tag, input logic [W-1:0] held);
        @(negedge clk);
        check({tag, ".readyLow"}, ready, 0);
        check({tag, ".held"}, Output, held);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        A     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst.Output", Output, 0);
        check("rst.sign", sign, 0);
        check("rst.is_min", is_min, 0);
        check("rst.busy", busy, 0);
        check("rst.ready", ready, 0);
        expectNoReady("idle.noReady", 20);

        applyStimulus(8'hFB);
        waitAndCheck("neg5", 1'b0, '0);
        checkPulseEnd("neg5", 8'h05);

        applyStimulus(8'h7F);
        waitAndCheck("pos7F", 1'b0, '0);
        checkPulseEnd("pos7F", 8'h7F);
        applyStimulus(8'h00);
        waitAndCheck("zero", 1'b0, '0);
        checkPulseEnd("zero", 8'h00);
        applyStimulus(8'h80);
        waitAndCheck("min", 1'b0, '0);
        checkPulseEnd("min", 8'h80);

        applyStimulus(8'hFF);
        waitAndCheck("busyIgnore", 1'b1, 8'h01);
        checkPulseEnd("busyIgnore", 8'h01);
        expectNoReady("busyIgnore.noExtra", 12);

        applyStimulus(8'hF0);
        waitAndCheck("b2b.first", 1'b0, '0);
        applyStimulus(8'h10);
        waitAndCheck("b2b.second", 1'b0, '0);
        checkPulseEnd("b2b.second", 8'h10);

        applyStimulus(8'h9C);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(expQ.pop_back());
        check("abort.Output", Output, 0);
        check("abort.sign", sign, 0);
        check("abort.is_min", is_min, 0);
        check("abort.busy", busy, 0);
        check("abort.ready", ready, 0);
        expectNoReady("abort.noReady", 15);
        applyStimulus(8'h9C);
        waitAndCheck("after.abort", 1'b0, '0);

        check("queueEmpty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/twos_decoder.md
Name: twos_decoder

Overview:
- Sequential decoder that converts a WIDTH-bit two's-complement value back to sign-magnitude form.
- It is the inverse of the datapath's two's-complement negation stage, and feeds display/compare logic that needs a sign bit plus an unsigned magnitude.
- Conversion is bit-serial, LSB first, using copy-until-first-one-then-invert. It is controlled by an en/ready handshake.

Parameters:
- WIDTH, 8, data width in bits (>=2)
- CNT_W, $clog2(WIDTH), bit-index counter width

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  start request; A is sampled when en=1 and the block is idle or done
- A  input  WIDTH  two's-complement operand
- Output  output  WIDTH  unsigned magnitude |A|
- sign  output  1  sign of captured A (A[WIDTH-1])
- is_min  output  1  captured A was the most-negative value (1 followed by zeros)
- busy  output  1  conversion in progress
- ready  output  1  one-cycle pulse when Output/sign/is_min are valid

Behaviour:
- Reset: synchronous and active-high. Sampled on the rising edge of clk.
  - State goes to IDLE.
  - Output=0, sign=0, is_min=0, busy=0, ready=0, counter=0, seen_one=0.
  - Reset overrides en and any in-flight conversion. Partial results are discarded and ready is never pulsed for an aborted operation.
- States:
  - IDLE: wait for en.
  - SHIFT: serial conversion.
  - DONE: ready=1 for one cycle.
- Transitions:
  - IDLE, en=1: capture A into shift register, sign<=A[WIDTH-1], counter<=0, seen_one<=0, busy<=1, go to SHIFT.
  - IDLE, en=0: stay in IDLE.
  - SHIFT, each cycle: process bit b = shreg[0].
    - out_bit = sign ? (seen_one ? ~b : b) : b.
    - seen_one <= seen_one | b.
    - Shift out_bit into Output from the MSB side; shift shreg right.
    - counter++.
  - SHIFT, counter==WIDTH-1: go to DONE, busy<=0, ready<=1.
  - DONE: ready=1 for exactly one cycle.
    - en=1 in DONE is accepted as a new capture (back-to-back, same action as IDLE+en).
    - Otherwise go to IDLE.
- Latency:
  - Capture edge E0, then WIDTH SHIFT edges.
  - ready is high in the cycle after edge E_WIDTH, i.e. WIDTH cycles after capture, independent of data.
  - Throughput: one conversion per WIDTH+1 cycles.
- Output updates:
  - Output is not held stable during SHIFT; it shifts live.
  - Output, sign and is_min are valid and held from the ready cycle until the next capture edge.
- en while busy (SHIFT): ignored, no queuing. A changes during SHIFT have no effect because the operand is registered.
- Arithmetic:
  - Positive or zero A: Output=A.
  - Negative A: Output=(~A+1) mod 2^WIDTH.
  - Most-negative value (0x80 at WIDTH=8): Output=0x80 (=128 unsigned), sign=1, is_min=1.
  - is_min is computed at capture: A[WIDTH-1]=1 and A[WIDTH-2:0]=0.
- No overflow is possible, since the magnitude is unsigned WIDTH bits.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - default data width constant (8), shared with the negation and adder blocks
- Natural sub-module: twos_serial_cell.
  - Combinational per-bit cell.
  - Inputs: b, sign, seen_one.
  - Outputs: out_bit, seen_one_next.
  - The FSM, counter and registers stay in twos_decoder.

Test Plan:
- reset high for 2 cycles, then low, en=0 -> Output=0, sign=0, is_min=0, busy=0, ready=0, no ready pulse for 20 cycles.
- en=1 for one cycle with A=8'hFB (-5) -> busy=1 for 8 cycles; ready pulses exactly 8 cycles after capture with Output=8'h05, sign=1, is_min=0.
- A=8'h7F, then after ready A=8'h00, then A=8'h80:
  - 8'h7F -> Output=8'h7F, sign=0.
  - 8'h00 -> Output=8'h00, sign=0.
  - 8'h80 -> Output=8'h80, sign=1, is_min=1.
- Capture A=8'hFF, then en=1 with A=8'h01 on every cycle of SHIFT -> second request ignored; single ready with Output=8'h01, sign=1.
- Back-to-back:
  - Capture A=8'hF0 (-16), then hold en=1 with A=8'h10 during the DONE cycle.
  - First ready: Output=8'h10, sign=1.
  - Second ready 9 cycles later: Output=8'h10, sign=0.
- Capture A=8'h9C, assert reset 3 cycles later for 1 cycle:
  - All outputs return to 0 on the next edge and no ready pulse occurs.
  - A fresh capture of 8'h9C then yields Output=8'h64, sign=1.
